// File: rtl/poly_sub_ctrl.sv
// Sequencer for one c = a - b mod q pass through the shared two-stage subtract unit.
// Define POLY_SUB_CTRL_PERF_CNT_EN to add the stall_cnt performance counter output.
module poly_sub_ctrl #(
  parameter int unsigned N       = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned SUB_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sub_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
`ifdef POLY_SUB_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned       L       = RD_LAT + SUB_LAT;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [L-1:0]      vld_q, vld_d;
  logic [ADDR_W-1:0] idx_q [L];
  logic [ADDR_W-1:0] idx_d [L];

  logic accept;
  logic issue;
  logic last_wr;

  assign accept  = (state_q == StIdle) & start;
  assign issue   = (state_q == StRun) & ~stall;
  assign last_wr = wr_en & (idx_q[L-1] == LastIdx);

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = issue;
  assign rd_addr = cnt_q;
  // The unit and the token pipeline freeze together, so operand data stays aligned.
  assign sub_en  = busy_q & ~stall;
  assign wr_en   = vld_q[L-1] & ~stall;
  assign wr_addr = idx_q[L-1];

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (issue) begin
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (last_wr) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    idx_d = idx_q;
    if (!stall) begin
      vld_d[0] = issue;
      idx_d[0] = cnt_q;
      for (int unsigned i = 1; i < L; i++) begin
        vld_d[i] = vld_q[i-1];
        idx_d[i] = idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < L; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int unsigned i = 0; i < L; i++) begin
        idx_q[i] <= idx_d[i];
      end
    end
  end

`ifdef POLY_SUB_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (busy_q && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Bench for poly_sub_ctrl: models operand RAMs, subtract unit and result RAM around the DUT,
// and checks the written polynomial against c[i] = (a[i] - b[i]) mod q.
module tb_poly_sub_ctrl;
  localparam int N      = 1024;
  localparam int ADDR_W = 10;
  localparam int L      = 3;
  localparam int Q      = 12289;
  localparam int LIMIT  = 6000;

  logic              clk = 1'b0;
  logic              rst_n, start, stall;
  logic              busy, done, rd_en, sub_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
`ifdef POLY_SUB_CTRL_PERF_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  poly_sub_ctrl #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .RD_LAT (1),
    .SUB_LAT(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .sub_en   (sub_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr)
`ifdef POLY_SUB_CTRL_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int mem_a   [N];
  int mem_b   [N];
  int res_mem [N];
  int exp_c   [N];
  int ra, rb, s1, s2;
  int issue_cnt = 0;
  int done_cnt  = 0;
  int stall_wr  = 0;
  int wr_log [$];
  int n_pass  = 0;
  int n_total = 0;

  // Environment: operand RAMs hold output when not read, subtract unit freezes on !sub_en.
  always @(posedge clk) begin
    if (rd_en) begin
      ra        <= mem_a[rd_addr];
      rb        <= mem_b[rd_addr];
      issue_cnt <= issue_cnt + 1;
    end
    if (sub_en) begin
      s1 <= (ra + Q - rb) % Q;
      s2 <= s1;
    end
    if (wr_en) begin
      res_mem[wr_addr] <= s2;
      wr_log.push_back(int'(wr_addr));
    end
    if (wr_en && stall) stall_wr <= stall_wr + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic run_op(input bit ramp, input int pre_st, input int st_len, input int dr_len,
                        input bit busy_starts, input int rnd_pct, output int done_cyc);
    int cyc, pre_left, mid_left, dr_left, nbst;
    int issue_base, done_base, wr_base, stwr_base, order_err, data_err, nwr;
    bit mid_fired, dr_fired, bs_fired, s;
    for (int i = 0; i < N; i++) begin
      if (ramp) begin
        mem_a[i] = i;
        mem_b[i] = 5;
      end else begin
        mem_a[i] = int'($urandom_range(Q - 1));
        mem_b[i] = int'($urandom_range(Q - 1));
      end
      exp_c[i] = (mem_a[i] - mem_b[i] + Q) % Q;
    end
    issue_base = issue_cnt;
    done_base  = done_cnt;
    wr_base    = wr_log.size();
    stwr_base  = stall_wr;
    nbst       = 0;
    mid_left   = 0;
    dr_left    = 0;
    mid_fired  = 1'b0;
    dr_fired   = 1'b0;
    bs_fired   = 1'b0;
    start      = 1'b1;
    stall      = (pre_st > 0);
    pre_left   = (pre_st > 0) ? pre_st - 1 : 0;
    step();
    start = 1'b0;
    cyc   = 1;
    check("busy_after_start", 32'(busy), 1);
    while (!done && cyc < LIMIT) begin
      s     = 1'b0;
      start = 1'b0;
      if (pre_left > 0) begin
        s = 1'b1;
        pre_left--;
      end else if (mid_left > 0) begin
        s = 1'b1;
        mid_left--;
      end else if (dr_left > 0) begin
        s = 1'b1;
        dr_left--;
      end else if (!mid_fired && st_len > 0 && rd_addr == 100 && issue_cnt - issue_base == 100) begin
        mid_fired = 1'b1;
        s         = 1'b1;
        mid_left  = st_len - 1;
      end else if (!dr_fired && dr_len > 0 && issue_cnt - issue_base == N) begin
        dr_fired = 1'b1;
        s        = 1'b1;
        dr_left  = dr_len - 1;
      end else if (rnd_pct > 0 && int'($urandom_range(99)) < rnd_pct) begin
        s = 1'b1;
      end
      if (busy_starts && !bs_fired && rd_addr == 10 && issue_cnt - issue_base == 10) begin
        start    = 1'b1;
        bs_fired = 1'b1;
      end
      stall = s;
      if (s && busy) nbst++;
      if (pre_st >= 2 && cyc == 1) begin
        #1;
        check("rd_en_while_start_stall", 32'({rd_en, sub_en}), 0);
      end
      if (pre_st > 0 && cyc == pre_st) begin
        #1;
        check("first_read_after_stall", 32'({rd_en, rd_addr}), 32'h400);
      end
      step();
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
    check("done_seen", 32'(done), 1);
    check("busy_in_done", 32'(busy), 0);
    done_cyc = cyc;
    check("done_cycle", cyc, N + L + 1 + nbst);
    if (busy_starts) start = 1'b1;
    step();
    start = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    if (busy_starts) begin
      repeat (5) step();
      check("no_extra_reads", issue_cnt - issue_base, N);
    end
    nwr = wr_log.size() - wr_base;
    check("wr_count", nwr, N);
    order_err = 0;
    for (int i = 0; i < N && i < nwr; i++) begin
      if (wr_log[wr_base + i] != i) order_err++;
    end
    data_err = 0;
    for (int i = 0; i < N; i++) begin
      if (res_mem[i] !== exp_c[i]) data_err++;
    end
    check("wr_order", order_err, 0);
    check("data", data_err, 0);
    check("wr_while_stalled", stall_wr - stwr_base, 0);
    check("done_pulses", done_cnt - done_base, 1);
    if (ramp) begin
      check("c0", res_mem[0], 12284);
      check("c4", res_mem[4], 12288);
      check("c5", res_mem[5], 0);
      check("c1023", res_mem[1023], 1018);
    end
`ifdef POLY_SUB_CTRL_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), (nbst > 65535) ? 65535 : nbst);
`endif
  endtask

  initial begin
    int dc, cyc, done_base, issue_base;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    #1;
    check("reset_outputs", 32'({busy, done, rd_en, sub_en, wr_en, rd_addr, wr_addr}), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("idle_no_reads", issue_cnt, 0);
    check("idle_no_writes", wr_log.size(), 0);
    check("idle_no_done", done_cnt, 0);
    check("idle_not_busy", 32'(busy), 0);

    run_op(1'b1, 0, 0, 0, 1'b0, 0, dc);
    check("basic_done_at_1028", dc, 1028);

    run_op(1'b0, 0, 7, 3, 1'b0, 0, dc);
    check("stalled_done_at_1038", dc, 1038);

    run_op(1'b0, 3, 0, 0, 1'b0, 0, dc);
    check("start_with_stall_done", dc, 1030);

    run_op(1'b0, 0, 0, 0, 1'b1, 0, dc);

    // Abort a run part-way with reset.
    done_base = done_cnt;
    start     = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (rd_addr != 500 && cyc < LIMIT) begin
      step();
      cyc++;
    end
    check("reached_addr_500", 32'(rd_addr), 500);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({busy, done, rd_en, sub_en, wr_en, rd_addr, wr_addr}), 0);
    issue_base = issue_cnt;
    repeat (3) step();
    check("no_reads_in_reset", issue_cnt - issue_base, 0);
    rst_n = 1'b1;
    step();
    check("no_done_after_reset", done_cnt - done_base, 0);
    run_op(1'b0, 0, 0, 0, 1'b0, 0, dc);

    run_op(1'b0, 0, 0, 0, 1'b0, 0, dc);
    run_op(1'b0, 0, 0, 0, 1'b0, 0, dc);
    check("back_to_back_done", dc, 1028);

    run_op(1'b0, 0, 0, 0, 1'b0, 25, dc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/poly_sub_ctrl.md
Name: poly_sub_ctrl

Overview:
- Sequencer that runs one full polynomial subtraction c = a - b mod q through the shared two-stage coefficient subtract unit.
- Issues read addresses to the two operand coefficient RAMs and drives the subtract unit's enable; operand data goes straight from RAM to the unit.
- Generates write address/enable for the result RAM, aligned to the pipeline output.
- Sits between the top-level NewHope command FSM (start/done) and the memory arbiter (stall).

Parameters:
- N, 1024, number of coefficients per polynomial.
- ADDR_W, 10, coefficient address width; N <= 2**ADDR_W.
- RD_LAT, 1, operand RAM read latency in cycles (rd_en to data valid).
- SUB_LAT, 2, subtract unit latency in enabled cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin an operation when idle.
- stall  in  1  arbiter hold; freezes the whole pipeline while high.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last result write.
- rd_en  out  1  read enable to both operand RAMs.
- rd_addr  out  ADDR_W  coefficient index read from both operand RAMs.
- sub_en  out  1  enable to the subtract unit.
- wr_en  out  1  result RAM write enable.
- wr_addr  out  ADDR_W  result RAM address, equal to the index of the coefficient being written.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, rd_en, sub_en, wr_en = 0; rd_addr, wr_addr, read counter and valid pipeline = 0.
- Total pipeline depth is L = RD_LAT + SUB_LAT, which is 3 by default.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN with read counter = 0.
  - start=0 -> stay in IDLE.
- RUN, each non-stalled cycle:
  - rd_en=1, rd_addr=counter, counter increments.
  - After issuing index N-1 -> DRAIN.
- DRAIN:
  - rd_en=0.
  - Wait until the last valid token leaves the pipeline (its wr_en cycle), then -> DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in the same cycle, then -> IDLE.
- Valid/address pipeline:
  - L-stage shift register of {valid, index}.
  - Stage 0 is loaded with {rd_en, rd_addr}.
  - Shifts only when stall=0.
  - wr_en = last-stage valid & ~stall; wr_addr = last-stage index.
- sub_en = busy & ~stall. The subtract unit freezes while sub_en=0, and the operand RAM outputs hold while rd_en=0, so data stays aligned with the valid pipeline.
- stall=1: rd_en=0, sub_en=0, wr_en=0. Counter, state and pipeline hold. Resume is lossless with no duplicate writes.
- start while busy (RUN, DRAIN or DONE): ignored with no side effects.
- start in the same cycle as stall from IDLE: accepted; the first read issues at the first non-stalled RUN cycle.
- Counter wrap: the counter never exceeds N-1. When N = 2**ADDR_W, the post-increment wrap to 0 is don't-care because the state has left RUN.
- Throughput: with no stall, done asserts N + L + 1 cycles after the start pulse. Writes are contiguous, indices 0..N-1 in order, each exactly once.
- Reset mid-operation returns to IDLE immediately. No done is issued, and partial results in the result RAM are undefined.

Optional Feature:
- Macro: POLY_SUB_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], the number of stall=1 cycles while busy in the current or last operation.
  - Cleared on an accepted start and on reset; saturates at 16'hFFFF; holds its value after done.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 -> all outputs 0; start=0 for 20 cycles -> no rd_en, wr_en or done.
- Basic run, N=1024, stall=0, a[i]=i, b[i]=5: 1024 writes with wr_addr 0..1023 in order. c[0..4] = 12289-5+i, c[5] = 0, c[i] = i-5 for i>=5. done exactly at cycle 1028 after start.
- Stall mid-stream: stall=1 for 7 cycles when rd_addr=100, and again for 3 cycles during DRAIN -> no wr_en while stalled; results identical to the no-stall case; done delayed by exactly 10 cycles; with the macro defined, stall_cnt=10.
- Start while busy: extra start pulses at rd_addr=10 and in the DONE cycle -> ignored; a single done and exactly N writes.
- Reset mid-run: rst_n=0 when rd_addr=500 -> outputs 0 immediately, no done. A new start runs a full clean 1024-write pass.
- Back-to-back: start in the cycle after done -> accepted; two full passes with correct results.
